// File: rtl/line_sched_pkg.sv
// Shared definitions for the line readout scheduler.
//   state_e    : sweep sequencing states
//   FIFO_DEPTH : depth of the tagged pixel FIFO
//   PIX_W      : pixel width
//   IDLE_LINE  : line selector value while idle (all ones, sliced to width by users)
package line_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLine,
        StStream,
        StRelease,
        StAdvance
    } state_e;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PIX_W      = 10;
    localparam logic [31:0] IDLE_LINE  = 32'hFFFF_FFFF;

endpackage

// File: rtl/pixel_tag_fifo.sv
// 4-entry synchronous FIFO of {line, col, last, data} pixel records.
//   clk, rst_n          : clock, async active-low reset (clears storage and pointers)
//   flush               : synchronous empty, priority over push/pop
//   push, push_*        : write a record (accepted when not full, or when popping)
//   pop                 : retire the head record (ignored when empty)
//   head_*              : head record, read straight from storage registers
//   full, empty, count  : occupancy status
module pixel_tag_fifo
    import line_sched_pkg::*;
#(
    parameter int unsigned LINE_W = 9,
    parameter int unsigned COL_W  = 10,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [LINE_W-1:0] push_line,
    input  logic [COL_W-1:0]  push_col,
    input  logic              push_last,
    input  logic [PIX_W-1:0]  push_data,
    input  logic              pop,
    output logic [LINE_W-1:0] head_line,
    output logic [COL_W-1:0]  head_col,
    output logic              head_last,
    output logic [PIX_W-1:0]  head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned ENTRY_W = LINE_W + COL_W + 1 + PIX_W;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign {head_line, head_col, head_last, head_data} = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_line, push_col, push_last, push_data};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/line_readout_scheduler.sv
// Sweeps lines first..last by step through the line buffer: selects a line, waits for
// the buffer's whole-line-ready flag, reads every column out into a tagged pixel stream,
// releases the buffer and advances.
//   clk, rst_n                    : clock, async active-low reset
//   start, abort                  : sweep request (IDLE only) / level abort
//   line_first/last/step          : sweep config, latched at start (step 0 acts as 1)
//   lb_interesting_line, lb_ready : buffer line selector / whole-line-ready flag
//   lb_read_address, lb_data      : buffer read port, data one cycle after address
//   lb_reset_ready                : one-cycle buffer release pulse
//   out_valid/ready/data/col/line/last : pixel stream
//   busy, done                    : activity flag / end-of-sweep pulse
module line_readout_scheduler
    import line_sched_pkg::*;
#(
    parameter int unsigned LINES   = 480,
    parameter int unsigned COLUMNS = 752,
    localparam int unsigned LINE_W = $clog2(LINES),
    localparam int unsigned COL_W  = $clog2(COLUMNS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LINE_W-1:0] line_first,
    input  logic [LINE_W-1:0] line_last,
    input  logic [LINE_W-1:0] line_step,
    output logic [LINE_W-1:0] lb_interesting_line,
    input  logic              lb_ready,
    output logic [COL_W-1:0]  lb_read_address,
    input  logic [PIX_W-1:0]  lb_data,
    output logic              lb_reset_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic [COL_W-1:0]  out_col,
    output logic [LINE_W-1:0] out_line,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned COL_LAST_I = COLUMNS - 1;
    localparam logic [COL_W:0]    COL_END  = COLUMNS[COL_W:0];
    localparam logic [COL_W-1:0]  COL_LAST = COL_LAST_I[COL_W-1:0];
    localparam logic [COL_W:0]    ISS_ONE  = (COL_W + 1)'(1);
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
    localparam logic [LINE_W-1:0] SEL_IDLE = IDLE_LINE[LINE_W-1:0];
    localparam logic [CNT_W:0]    PEND_MAX = FIFO_DEPTH[CNT_W:0];

    state_e state_q, state_d;

    logic [LINE_W-1:0] cur_q, cur_d, last_q, last_d, step_q, step_d, sel_q, sel_d;
    logic [COL_W:0]    issue_cnt_q, issue_cnt_d;
    logic              inflight_q, inflight_d;
    logic [COL_W-1:0]  inflight_col_q, inflight_col_d;
    logic              rr_q, rr_d, done_q, done_d, busy_q, busy_d;

    logic              issue, push, pop, flush;
    logic [LINE_W-1:0] step_eff;
    logic [LINE_W:0]   next_line;
    logic              next_past_end;
    logic [CNT_W:0]    pending;
    logic              fifo_full, fifo_empty, head_last;
    logic [CNT_W-1:0]  fifo_count;

    // Extra top bit keeps current + step from wrapping back into range.
    assign step_eff      = (step_q == '0) ? LINE_ONE : step_q;
    assign next_line     = {1'b0, cur_q} + {1'b0, step_eff};
    assign next_past_end = next_line > {1'b0, last_q};

    // Reads in flight plus stored pixels bound the FIFO, so a return always has a slot.
    assign pending = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign pop     = !fifo_empty && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !(line_first > line_last)) state_d = StWaitLine;
            end
            StWaitLine: begin
                if (abort)         state_d = StIdle;
                else if (lb_ready) state_d = StStream;
            end
            StStream: begin
                if (abort)                 state_d = StIdle;
                else if (pop && head_last) state_d = StRelease;
            end
            StRelease: begin
                state_d = abort ? StIdle : StAdvance;
            end
            StAdvance: begin
                if (abort || next_past_end) state_d = StIdle;
                else                        state_d = StWaitLine;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cur_d          = cur_q;
        last_d         = last_q;
        step_d         = step_q;
        issue_cnt_d    = issue_cnt_q;
        done_d         = 1'b0;
        rr_d           = 1'b0;
        flush          = abort && (state_q != StIdle);
        issue          = (state_q == StStream) && !abort && (issue_cnt_q < COL_END)
                         && (pending < PEND_MAX);
        push           = inflight_q && (state_q == StStream) && !abort && (!fifo_full || pop);
        inflight_d     = issue;
        inflight_col_d = issue_cnt_q[COL_W-1:0];

        if (state_q == StIdle && start) begin
            cur_d  = line_first;
            last_d = line_last;
            step_d = line_step;
            done_d = line_first > line_last;
        end
        if (state_q == StAdvance && !abort) begin
            if (next_past_end) done_d = 1'b1;
            else               cur_d  = next_line[LINE_W-1:0];
        end

        if (state_q == StWaitLine) issue_cnt_d = '0;
        else if (issue)            issue_cnt_d = issue_cnt_q + ISS_ONE;

        // Release whenever the buffer has been claimed, including on abort.
        if (abort) begin
            rr_d = (state_q == StStream) || (state_q == StWaitLine && lb_ready);
        end else begin
            rr_d = (state_q == StStream) && (state_d == StRelease);
        end

        busy_d = (state_d != StIdle);

        case (state_d)
            StIdle:     sel_d = SEL_IDLE;
            StWaitLine: sel_d = cur_d;
            // Present the next line as soon as the release pulse is done.
            StAdvance:  sel_d = next_past_end ? SEL_IDLE : next_line[LINE_W-1:0];
            default:    sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q          <= '0;
            last_q         <= '0;
            step_q         <= '0;
            issue_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_col_q <= '0;
            sel_q          <= SEL_IDLE;
            rr_q           <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            cur_q          <= cur_d;
            last_q         <= last_d;
            step_q         <= step_d;
            issue_cnt_q    <= issue_cnt_d;
            inflight_q     <= inflight_d;
            inflight_col_q <= inflight_col_d;
            sel_q          <= sel_d;
            rr_q           <= rr_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    pixel_tag_fifo #(
        .LINE_W (LINE_W),
        .COL_W  (COL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_line (cur_q),
        .push_col  (inflight_col_q),
        .push_last (inflight_col_q == COL_LAST),
        .push_data (lb_data),
        .pop       (pop),
        .head_line (out_line),
        .head_col  (out_col),
        .head_last (head_last),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid           = !fifo_empty;
    assign out_last            = head_last;
    assign lb_interesting_line = sel_q;
    assign lb_read_address     = issue_cnt_q[COL_W-1:0];
    assign lb_reset_ready      = rr_q;
    assign done                = done_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_line_readout_scheduler.sv
module tb_line_readout_scheduler;

    localparam int LINES   = 8;
    localparam int COLUMNS = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] line_first = '0;
    logic [2:0] line_last = '0;
    logic [2:0] line_step = '0;
    logic [2:0] lb_interesting_line;
    logic       lb_ready = 1'b0;
    logic [2:0] lb_read_address;
    logic [9:0] lb_data = '0;
    logic       lb_reset_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_data;
    logic [2:0] out_col;
    logic [2:0] out_line;
    logic       out_last;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_pct = 100;
    bit stable_en = 1'b1;
    int rr_cnt = 0;
    int done_cnt = 0;
    int exp_line[$];
    int exp_col[$];

    line_readout_scheduler #(
        .LINES   (LINES),
        .COLUMNS (COLUMNS)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .line_first          (line_first),
        .line_last           (line_last),
        .line_step           (line_step),
        .lb_interesting_line (lb_interesting_line),
        .lb_ready            (lb_ready),
        .lb_read_address     (lb_read_address),
        .lb_data             (lb_data),
        .lb_reset_ready      (lb_reset_ready),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_col             (out_col),
        .out_line            (out_line),
        .out_last            (out_last),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Pixel content the buffer holds for a given line and column.
    function automatic logic [9:0] pix(input int l, input int c);
        return 10'((l * 97 + c * 13 + 3) % 1024);
    endfunction

    // Line buffer model: data one cycle after address, line ready a few cycles after
    // the scheduler starts waiting, ready dropped on release. Also drives out_ready.
    initial begin : buffer_model
        int wcnt;
        logic nr;
        logic [9:0] nd;
        wcnt = 2;
        forever begin
            @(negedge clk);
            nd = pix(int'(lb_interesting_line), int'(lb_read_address));
            nr = lb_ready;
            if (!rst_n || !busy || lb_reset_ready) begin
                nr = 1'b0;
                wcnt = $urandom_range(4, 2);
            end else if (!lb_ready) begin
                if (wcnt == 0) nr = 1'b1;
                else wcnt = wcnt - 1;
            end
            @(posedge clk);
            #1;
            lb_data = nd;
            lb_ready = nr;
            out_ready = ($urandom_range(99, 0) < ready_pct);
        end
    end

    // Stream monitor: pixel order/content, stall stability, gaps, first-pixel latency.
    initial begin : monitor
        logic prev_stall, prev_hs_nl, prev_rdy, plast, want_last;
        logic [9:0] pd;
        logic [2:0] pc, pl;
        int rise_cyc, el, ec;
        bit line_started;
        prev_stall = 1'b0; prev_hs_nl = 1'b0; prev_rdy = 1'b0; line_started = 1'b1;
        rise_cyc = 0; pd = '0; pc = '0; pl = '0; plast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0; prev_hs_nl = 1'b0; prev_rdy = 1'b0; line_started = 1'b1;
                continue;
            end
            if (lb_reset_ready) rr_cnt = rr_cnt + 1;
            if (done) done_cnt = done_cnt + 1;
            if (busy && lb_ready && !prev_rdy) begin
                rise_cyc = cyc;
                line_started = 1'b0;
            end
            prev_rdy = lb_ready;
            if (out_valid && !line_started) begin
                line_started = 1'b1;
                total = total + 1;
                if (cyc != rise_cyc + 3) begin
                    bad = bad + 1;
                    $display("FAIL latency: first valid %0d cycles after ready, want 3",
                             cyc - rise_cyc);
                end
            end
            if (!stable_en) begin
                prev_stall = 1'b0;
                prev_hs_nl = 1'b0;
            end
            if (prev_stall) begin
                total = total + 1;
                if (!out_valid || out_data !== pd || out_col !== pc || out_line !== pl
                    || out_last !== plast) begin
                    bad = bad + 1;
                    $display("FAIL stall_stable: valid=%0b line=%0d col=%0d data=%0d, want held line=%0d col=%0d data=%0d",
                             out_valid, out_line, out_col, out_data, pl, pc, pd);
                end
            end
            if (prev_hs_nl && ready_pct == 100) begin
                total = total + 1;
                if (out_valid !== 1'b1) begin
                    bad = bad + 1;
                    $display("FAIL gap: out_valid=%0b mid-line with ready held, want 1", out_valid);
                end
            end
            if (out_valid && out_ready) begin
                total = total + 1;
                if (exp_line.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL extra_pixel: got line=%0d col=%0d, want none", out_line, out_col);
                end else begin
                    el = exp_line.pop_front();
                    ec = exp_col.pop_front();
                    want_last = (ec == COLUMNS - 1);
                    if (int'(out_line) != el || int'(out_col) != ec || out_last !== want_last
                        || out_data !== pix(el, ec)) begin
                        bad = bad + 1;
                        $display("FAIL pixel: got line=%0d col=%0d last=%0b data=%0d, want line=%0d col=%0d last=%0b data=%0d",
                                 out_line, out_col, out_last, out_data, el, ec, want_last,
                                 pix(el, ec));
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_hs_nl = out_valid && out_ready && !out_last;
            pd = out_data; pc = out_col; pl = out_line; plast = out_last;
        end
    end

    task automatic build_expect(input int first, input int last, input int step, output int nl);
        int se;
        se = (step == 0) ? 1 : step;
        nl = 0;
        exp_line.delete();
        exp_col.delete();
        if (first <= last) begin
            for (int l = first; l <= last; l += se) begin
                nl++;
                for (int c = 0; c < COLUMNS; c++) begin
                    exp_line.push_back(l);
                    exp_col.push_back(c);
                end
            end
        end
    endtask

    task automatic pulse_start(input int first, input int last, input int step);
        @(posedge clk);
        #1;
        line_first = 3'(first);
        line_last = 3'(last);
        line_step = 3'(step);
        rr_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input string name, input int first, input int last,
                             input int step, input int pct);
        int nl;
        int i;
        ready_pct = pct;
        build_expect(first, last, step, nl);
        pulse_start(first, last, step);
        @(negedge clk);
        if (first <= last) begin
            total++;
            if (busy !== 1'b1 || int'(lb_interesting_line) != first) begin
                bad++;
                $display("FAIL %s start: busy=%0b sel=%0d, want busy=1 sel=%0d",
                         name, busy, lb_interesting_line, first);
            end
        end
        i = 0;
        while (done_cnt == 0 && i < 5000) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s timeout: no done after %0d cycles, want done", name, i);
        end
        repeat (2) @(negedge clk);
        total++;
        if (exp_line.size() != 0) begin
            bad++;
            $display("FAIL %s pixels_left: %0d missing, want 0", name, exp_line.size());
        end
        total++;
        if (rr_cnt != nl) begin
            bad++;
            $display("FAIL %s releases: got %0d, want %0d", name, rr_cnt, nl);
        end
        total++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s end: done pulses=%0d busy=%0b, want 1 and 0", name, done_cnt, busy);
        end
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if (lb_interesting_line !== 3'b111 || lb_read_address !== 3'd0 || lb_reset_ready !== 1'b0
            || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s ctrl: sel=%0d addr=%0d rr=%0b valid=%0b last=%0b busy=%0b done=%0b, want 7 0 0 0 0 0 0",
                     name, lb_interesting_line, lb_read_address, lb_reset_ready, out_valid,
                     out_last, busy, done);
        end
        total++;
        if (out_data !== 10'd0 || out_col !== 3'd0 || out_line !== 3'd0) begin
            bad++;
            $display("FAIL %s data: data=%0d col=%0d line=%0d, want 0 0 0",
                     name, out_data, out_col, out_line);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_basic();
        run_sweep("basic", 2, 6, 2, 100);
    endtask

    task automatic test_random_ready();
        int f, l, s;
        for (int k = 0; k < 4; k++) begin
            f = $urandom_range(LINES - 1, 0);
            l = $urandom_range(LINES - 1, f);
            s = $urandom_range(3, 0);
            run_sweep("random_ready", f, l, s, 30);
        end
        ready_pct = 100;
    endtask

    task automatic test_boundaries();
        run_sweep("empty_range", 5, 3, 1, 100);
        run_sweep("step_zero", 1, 4, 0, 100);
        run_sweep("no_wrap", 0, LINES - 1, 7, 100);
    endtask

    task automatic test_abort();
        int nl;
        int i;
        ready_pct = 100;
        build_expect(0, LINES - 1, 1, nl);
        pulse_start(0, LINES - 1, 1);
        i = 0;
        while (exp_line.size() > nl * COLUMNS - 8 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        stable_en = 1'b0;
        @(posedge clk);
        #1;
        rr_cnt = 0;
        done_cnt = 0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || lb_reset_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_next: valid=%0b busy=%0b rr=%0b, want 0 0 1",
                     out_valid, busy, lb_reset_ready);
        end
        repeat (6) @(negedge clk);
        total++;
        if (rr_cnt != 1 || done_cnt != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_after: releases=%0d done=%0d busy=%0b valid=%0b, want 1 0 0 0",
                     rr_cnt, done_cnt, busy, out_valid);
        end
        exp_line.delete();
        exp_col.delete();
        stable_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int nl;
        int i;
        ready_pct = 100;
        build_expect(0, 3, 1, nl);
        pulse_start(0, 3, 1);
        i = 0;
        while (exp_line.size() > nl * COLUMNS - 3 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        stable_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_line.delete();
        exp_col.delete();
        stable_en = 1'b1;
        run_sweep("after_reset", 1, 5, 2, 100);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_boundaries();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
